e203_tcm_ram_pmu: RTL and testbench
===================================

Name: e203_tcm_ram_pmu

Overview:
- Parametrised successor to the fixed ITCM/DTCM RAM wrappers: one generic TCM SRAM model with configurable width, depth and byte-mask granularity.
- Adds a real power-management state machine on top of the storage array: light-sleep, deep-sleep and shutdown, with wake-up latency, a ready indication and optional zero-fill after shutdown.
- Instantiated once per TCM inside the SRAM top in place of the per-TCM RAM wrappers.

Parameters:
- DW, 64, data width in bits; must be a multiple of MW.
- DP, 8192, depth in words.
- AW, 13, address width; must satisfy 2^AW >= DP.
- MW, 8, write-mask width; each mask bit covers DW/MW data bits.
- LS_WAKE, 1, cycles in WAKE after leaving light-sleep; 0 means return to RUN directly.
- DS_WAKE, 4, cycles in WAKE after leaving deep-sleep or shutdown; must be >= 1.
- SD_INIT, 1, when 1, leaving shutdown zero-fills the whole array before RUN.

Ports:
- clk_tcm_ram  in  1  RAM clock; the only clock.
- rst_tcm  in  1  reset, synchronous and active-high.
- test_mode  in  1  when 1, forces sd/ds/ls to be ignored.
- ram_sd  in  1  shutdown request; level-sensitive.
- ram_ds  in  1  deep-sleep request; level-sensitive.
- ram_ls  in  1  light-sleep request; level-sensitive.
- ram_cs  in  1  chip select.
- ram_we  in  1  1 = write, 0 = read.
- ram_addr  in  AW  word address.
- ram_wem  in  MW  byte write mask.
- ram_din  in  DW  write data.
- ram_dout  out  DW  registered read data.
- ram_dout_vld  out  1  one-cycle pulse when ram_dout has just been updated by a read.
- ram_rdy  out  1  registered; 1 iff the FSM is in RUN.

Behaviour:
- Only clk_tcm_ram exists; rst_tcm is sampled on its rising edge.
- Reset values: state RUN, ram_rdy=1, ram_dout=0, ram_dout_vld=0, counters 0. Array contents are not reset.
- Effective requests: sd_e = ram_sd & ~test_mode; ds_e = ram_ds & ~test_mode; ls_e = ram_ls & ~test_mode. Priority is sd_e > ds_e > ls_e.
- Access accepted iff state==RUN & ram_cs & ~(sd_e|ds_e|ls_e). On a same-cycle conflict the sleep request wins and the access is dropped silently.
- Write (accepted, ram_we=1): for each mask bit i that is set, update bits [i*DW/MW +: DW/MW]. ram_dout is unchanged and no ram_dout_vld pulse.
- Read (accepted, ram_we=0): ram_dout <= mem[addr] and ram_dout_vld=1 on the next edge, i.e. 1-cycle latency.
- When no read is accepted, ram_dout holds and ram_dout_vld=0.
- Address >= DP: writes are ignored; reads return 0 and still pulse ram_dout_vld.
- FSM states: RUN, LS, DS, SD, WAKE, INIT.
- RUN: on sd_e go to SD; else on ds_e go to DS; else on ls_e go to LS. All transitions take effect on the next edge; ram_rdy falls on that same edge.
- LS: on sd_e go to SD; on ds_e go to DS. When all requests are low, go to WAKE with count=LS_WAKE, or directly to RUN if LS_WAKE==0.
- DS: on sd_e go to SD; if ~ds_e & ls_e go to LS. When all requests are low, go to WAKE with count=DS_WAKE.
- SD: ram_dout is cleared to 0 on entry. When sd_e is low:
  - SD_INIT=1: go to INIT with index 0.
  - SD_INIT=0: go to WAKE with count=DS_WAKE (the array content is then undefined and must not be checked).
  - Requests ds_e/ls_e seen while leaving SD are honoured only after RUN is reached.
- WAKE: count decrements each cycle; at count==1 go to RUN. Any effective request during WAKE aborts the wake and jumps to the matching sleep state using the RUN priority.
- INIT: writes zero to mem[index] each cycle and increments index. After index==DP-1 go to RUN, so INIT lasts exactly DP cycles. Requests are ignored during INIT except sd_e, which returns to SD and restarts INIT on the next exit.
- test_mode=1 while in any sleep state: behaves as if all requests dropped (normal exit path, not an instant jump).
- Reset mid-operation (any state, including mid-INIT or mid-WAKE) returns to RUN on the next edge. A partial INIT is not resumed.
- Sleep states LS and DS retain array contents and hold ram_dout.

Test Plan:
- Run all scenarios with DW=32, DP=16, AW=4, MW=4, LS_WAKE=1, DS_WAKE=3, SD_INIT=1.
- Masked write/read: write 0xAABBCCDD to addr 3 with wem=4'hF, then write 0x11223344 with wem=4'b0101; read addr 3 -> next cycle ram_dout=0xAA22CC44, ram_dout_vld=1 for exactly one cycle.
- Light-sleep round trip: assert ls for 5 cycles then drop -> ram_rdy=0 from the edge after assertion through LS and 1 WAKE cycle, then ram_rdy=1. A read of addr 3 returns 0xAA22CC44; a cs held during LS produces no ram_dout_vld.
- Deep-sleep aborted wake: enter DS, drop ds, re-assert ls on the 2nd WAKE cycle -> FSM enters LS, ram_rdy stays 0; after ls drops, RUN is reached 1 cycle later and contents are retained.
- Shutdown with zero-fill: write 0xFFFFFFFF to all 16 addresses, pulse sd for 3 cycles -> ram_dout=0, ram_rdy=0 for exactly 16 INIT cycles after sd drops; every read afterwards returns 0.
- Priority and test_mode: assert cs(read), ls and sd in the same cycle -> no ram_dout_vld, FSM enters SD. With test_mode=1, ls/ds/sd held high -> ram_rdy stays 1 and reads proceed normally.
- Reset mid-INIT: assert rst_tcm at INIT index 7 -> next cycle ram_rdy=1, ram_dout=0, ram_dout_vld=0. A read of addr 2 (already zeroed) returns 0; addr 12 is not checked (content undefined).

Source files
------------

// File: rtl/e203_tcm_ram_pmu_if.sv
`default_nettype none
// ---- e203_tcm_ram_pmu_if : TCM SRAM access and power-request bundle -- rev 1.0 ----
interface e203_tcm_ram_pmu_if #(
   parameter int DW = 64,
   parameter int AW = 13,
   parameter int MW = 8
);
   logic          test_mode;
   logic          ram_sd;
   logic          ram_ds;
   logic          ram_ls;
   logic          ram_cs;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [MW-1:0] ram_wem;
   logic [DW-1:0] ram_din;
   logic [DW-1:0] ram_dout;
   logic          ram_dout_vld;
   logic          ram_rdy;

   modport master (
      output test_mode, ram_sd, ram_ds, ram_ls, ram_cs, ram_we, ram_addr, ram_wem, ram_din,
      input  ram_dout, ram_dout_vld, ram_rdy
   );

   modport slave (
      input  test_mode, ram_sd, ram_ds, ram_ls, ram_cs, ram_we, ram_addr, ram_wem, ram_din,
      output ram_dout, ram_dout_vld, ram_rdy
   );
endinterface
`default_nettype wire

// File: rtl/e203_tcm_ram_pmu.sv
`default_nettype none
// ---- e203_tcm_ram_pmu : generic TCM SRAM with light/deep-sleep and shutdown FSM -- rev 1.0 ----
module e203_tcm_ram_pmu #(
   parameter int DW      = 64,
   parameter int DP      = 8192,
   parameter int AW      = 13,
   parameter int MW      = 8,
   parameter int LS_WAKE = 1,
   parameter int DS_WAKE = 4,
   parameter int SD_INIT = 1
) (
   input  logic clk_tcm_ram,
   input  logic rst_tcm,
   e203_tcm_ram_pmu_if.slave bus
);
   localparam int SW   = DW / MW;
   localparam int WMAX = (LS_WAKE > DS_WAKE) ? LS_WAKE : DS_WAKE;
   localparam int CW   = (WMAX < 2) ? 1 : $clog2(WMAX + 1);
   localparam int AW1  = AW + 1;
   localparam logic [CW-1:0]  LS_CNT   = CW'(LS_WAKE);
   localparam logic [CW-1:0]  DS_CNT   = CW'(DS_WAKE);
   localparam logic [AW-1:0]  LAST_IDX = AW'(DP - 1);
   localparam logic [AW:0]    DEPTH    = AW1'(DP);

   typedef enum logic [2:0] {
      ST_RUN  = 3'd0,
      ST_LS   = 3'd1,
      ST_DS   = 3'd2,
      ST_SD   = 3'd3,
      ST_WAKE = 3'd4,
      ST_INIT = 3'd5
   } state_t;

   state_t        state;
   logic [CW-1:0] count;
   logic [AW-1:0] index;
   logic [DW-1:0] mem [DP];
   logic [DW-1:0] dout;
   logic          dout_vld;
   logic          rdy;

   logic sd_e, ds_e, ls_e, any_req, in_range, acc, rd_acc, wr_acc, init_wr;

   always_comb begin
      sd_e     = bus.ram_sd & ~bus.test_mode;
      ds_e     = bus.ram_ds & ~bus.test_mode;
      ls_e     = bus.ram_ls & ~bus.test_mode;
      any_req  = sd_e | ds_e | ls_e;
      in_range = {1'b0, bus.ram_addr} < DEPTH;
      acc      = (state == ST_RUN) & bus.ram_cs & ~any_req;
      rd_acc   = acc & ~bus.ram_we;
      wr_acc   = acc & bus.ram_we & in_range & ~rst_tcm;
      init_wr  = (state == ST_INIT) & ~sd_e & ~rst_tcm;
   end

   function automatic state_t sleep_target(input logic sd, input logic ds);
      if (sd)      return ST_SD;
      else if (ds) return ST_DS;
      else         return ST_LS;
   endfunction

   // Storage has no reset; zero-fill after shutdown is done by the INIT sweep.
   always_ff @(posedge clk_tcm_ram) begin
      if (init_wr) begin
         mem[index] <= '0;
      end else if (wr_acc) begin
         for (int i = 0; i < MW; i++) begin
            if (bus.ram_wem[i]) mem[bus.ram_addr][i*SW +: SW] <= bus.ram_din[i*SW +: SW];
         end
      end
   end

   always_ff @(posedge clk_tcm_ram) begin
      state_t nxt;
      if (rst_tcm) begin
         state    <= ST_RUN;
         rdy      <= 1'b1;
         dout     <= '0;
         dout_vld <= 1'b0;
         count    <= '0;
         index    <= '0;
      end else begin
         nxt = state;
         dout_vld <= rd_acc;
         if (rd_acc) dout <= in_range ? mem[bus.ram_addr] : '0;
         case (state)
            ST_RUN: begin
               if (any_req) nxt = sleep_target(sd_e, ds_e);
            end
            ST_LS: begin
               if (sd_e | ds_e) begin
                  nxt = sleep_target(sd_e, ds_e);
               end else if (!ls_e) begin
                  if (LS_WAKE == 0) begin
                     nxt = ST_RUN;
                  end else begin
                     nxt   = ST_WAKE;
                     count <= LS_CNT;
                  end
               end
            end
            ST_DS: begin
               if (sd_e) begin
                  nxt = ST_SD;
               end else if (!ds_e && ls_e) begin
                  nxt = ST_LS;
               end else if (!ds_e) begin
                  nxt   = ST_WAKE;
                  count <= DS_CNT;
               end
            end
            ST_SD: begin
               // Pending ds/ls are deliberately ignored on the way out of shutdown.
               if (!sd_e) begin
                  if (SD_INIT != 0) begin
                     nxt   = ST_INIT;
                     index <= '0;
                  end else begin
                     nxt   = ST_WAKE;
                     count <= DS_CNT;
                  end
               end
            end
            ST_WAKE: begin
               if (any_req) begin
                  nxt = sleep_target(sd_e, ds_e);
               end else if (count == CW'(1)) begin
                  nxt = ST_RUN;
               end else begin
                  count <= count - CW'(1);
               end
            end
            ST_INIT: begin
               if (sd_e) begin
                  nxt = ST_SD;
               end else if (index == LAST_IDX) begin
                  nxt = ST_RUN;
               end else begin
                  index <= index + AW'(1);
               end
            end
            default: nxt = ST_RUN;
         endcase
         if (nxt == ST_SD && state != ST_SD) dout <= '0;
         state <= nxt;
         rdy   <= (nxt == ST_RUN);
      end
   end

   assign bus.ram_dout     = dout;
   assign bus.ram_dout_vld = dout_vld;
   assign bus.ram_rdy      = rdy;
endmodule
`default_nettype wire

// File: tb/tb_e203_tcm_ram_pmu.sv
`timescale 1ns/1ps
`default_nettype none
// ---- tb_e203_tcm_ram_pmu : scenario bench with a word/byte-lane memory model -- rev 1.0 ----
module tb_e203_tcm_ram_pmu;
   localparam int DW = 32, DP = 16, AW = 4, MW = 4, LS_WAKE = 1, DS_WAKE = 3, SD_INIT = 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;
   logic [DW-1:0] model_mem [DP];
   logic [DW-1:0] model_dout = '0;

   e203_tcm_ram_pmu_if #(.DW(DW), .AW(AW), .MW(MW)) bus();

   e203_tcm_ram_pmu #(
      .DW(DW), .DP(DP), .AW(AW), .MW(MW),
      .LS_WAKE(LS_WAKE), .DS_WAKE(DS_WAKE), .SD_INIT(SD_INIT)
   ) dut (
      .clk_tcm_ram (clk),
      .rst_tcm     (rst),
      .bus         (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.test_mode = 1'b0;
      bus.ram_sd = 1'b0;  bus.ram_ds = 1'b0;  bus.ram_ls = 1'b0;
      bus.ram_cs = 1'b0;  bus.ram_we = 1'b0;
      bus.ram_addr = '0;  bus.ram_wem = '0;   bus.ram_din = '0;
   endtask

   task automatic model_write(input int a, input logic [MW-1:0] m, input logic [DW-1:0] d);
      for (int i = 0; i < MW; i++)
         if (m[i]) model_mem[a][i*8 +: 8] = d[i*8 +: 8];
   endtask

   task automatic drive_write(input int a, input logic [MW-1:0] m, input logic [DW-1:0] d);
      bus.ram_cs = 1'b1; bus.ram_we = 1'b1; bus.ram_addr = AW'(a); bus.ram_wem = m; bus.ram_din = d;
      tick();
      bus.ram_cs = 1'b0; bus.ram_we = 1'b0;
      model_write(a, m, d);
   endtask

   task automatic drive_read(input int a);
      bus.ram_cs = 1'b1; bus.ram_we = 1'b0; bus.ram_addr = AW'(a);
      tick();
      bus.ram_cs = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      vectors++; if (bus.ram_rdy !== 1'b1) begin miscompares++; $display("FAIL reset_rdy got %b want 1", bus.ram_rdy); end
      vectors++; if (bus.ram_dout !== '0) begin miscompares++; $display("FAIL reset_dout got %h want 0", bus.ram_dout); end
      vectors++; if (bus.ram_dout_vld !== 1'b0) begin miscompares++; $display("FAIL reset_vld got %b want 0", bus.ram_dout_vld); end
      model_dout = '0;
   endtask

   task automatic test_masked_rw();
      drive_write(3, 4'hF, 32'hAABBCCDD);
      drive_write(3, 4'b0101, 32'h11223344);
      drive_read(3);
      vectors++; if (bus.ram_dout !== 32'hAA22CC44) begin miscompares++; $display("FAIL masked_dout got %h want aa22cc44", bus.ram_dout); end
      vectors++; if (bus.ram_dout_vld !== 1'b1) begin miscompares++; $display("FAIL masked_vld got %b want 1", bus.ram_dout_vld); end
      model_dout = 32'hAA22CC44;
      tick();
      vectors++; if (bus.ram_dout_vld !== 1'b0) begin miscompares++; $display("FAIL masked_vld_pulse got %b want 0", bus.ram_dout_vld); end
      vectors++; if (bus.ram_dout !== model_dout) begin miscompares++; $display("FAIL masked_hold got %h want %h", bus.ram_dout, model_dout); end
   endtask

   task automatic test_light_sleep();
      bus.ram_ls = 1'b1;
      bus.ram_cs = 1'b1; bus.ram_we = 1'b0; bus.ram_addr = AW'(3);
      for (int k = 0; k < 5; k++) begin
         tick();
         vectors++; if (bus.ram_rdy !== 1'b0) begin miscompares++; $display("FAIL ls_rdy[%0d] got %b want 0", k, bus.ram_rdy); end
         vectors++; if (bus.ram_dout_vld !== 1'b0) begin miscompares++; $display("FAIL ls_vld[%0d] got %b want 0", k, bus.ram_dout_vld); end
         vectors++; if (bus.ram_dout !== model_dout) begin miscompares++; $display("FAIL ls_dout[%0d] got %h want %h", k, bus.ram_dout, model_dout); end
      end
      bus.ram_ls = 1'b0; bus.ram_cs = 1'b0;
      tick();
      vectors++; if (bus.ram_rdy !== 1'b0) begin miscompares++; $display("FAIL ls_wake_rdy got %b want 0", bus.ram_rdy); end
      tick();
      vectors++; if (bus.ram_rdy !== 1'b1) begin miscompares++; $display("FAIL ls_run_rdy got %b want 1", bus.ram_rdy); end
      drive_read(3);
      model_dout = model_mem[3];
      vectors++; if (bus.ram_dout !== model_dout || bus.ram_dout_vld !== 1'b1) begin
         miscompares++; $display("FAIL ls_retain got %h/%b want %h/1", bus.ram_dout, bus.ram_dout_vld, model_dout);
      end
   endtask

   task automatic test_ds_abort();
      bus.ram_ds = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         vectors++; if (bus.ram_rdy !== 1'b0) begin miscompares++; $display("FAIL ds_rdy[%0d] got %b want 0", k, bus.ram_rdy); end
      end
      bus.ram_ds = 1'b0;
      tick();   // first WAKE cycle
      tick();   // second WAKE cycle
      vectors++; if (bus.ram_rdy !== 1'b0) begin miscompares++; $display("FAIL ds_wake_rdy got %b want 0", bus.ram_rdy); end
      bus.ram_ls = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         vectors++; if (bus.ram_rdy !== 1'b0) begin miscompares++; $display("FAIL ds_abort_rdy[%0d] got %b want 0", k, bus.ram_rdy); end
      end
      bus.ram_ls = 1'b0;
      tick();
      vectors++; if (bus.ram_rdy !== 1'b0) begin miscompares++; $display("FAIL ds_ls_wake_rdy got %b want 0", bus.ram_rdy); end
      tick();
      vectors++; if (bus.ram_rdy !== 1'b1) begin miscompares++; $display("FAIL ds_run_rdy got %b want 1", bus.ram_rdy); end
      for (int a = 0; a < DP; a += 5) begin
         drive_read(a);
         model_dout = model_mem[a];
         vectors++; if (bus.ram_dout !== model_dout) begin miscompares++; $display("FAIL ds_retain[%0d] got %h want %h", a, bus.ram_dout, model_dout); end
      end
   endtask

   task automatic random_ops(input string tag, input int n);
      for (int k = 0; k < n; k++) begin
         logic cs, we, exp_vld;
         int a;
         logic [MW-1:0] m;
         logic [DW-1:0] d;
         cs = ($urandom_range(0, 3) != 0);
         we = $urandom_range(0, 1) == 1;
         a  = $urandom_range(0, DP - 1);
         m  = MW'($urandom);
         d  = $urandom;
         bus.ram_cs = cs; bus.ram_we = we; bus.ram_addr = AW'(a); bus.ram_wem = m; bus.ram_din = d;
         tick();
         exp_vld = cs && !we;
         if (cs && we) model_write(a, m, d);
         if (exp_vld) model_dout = model_mem[a];
         vectors++; if (bus.ram_dout_vld !== exp_vld || bus.ram_dout !== model_dout || bus.ram_rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s[%0d] dout/vld/rdy got %h/%b/%b want %h/%b/1", tag, k,
                     bus.ram_dout, bus.ram_dout_vld, bus.ram_rdy, model_dout, exp_vld);
         end
      end
      bus.ram_cs = 1'b0;
   endtask

   task automatic test_random_rw();
      for (int a = 0; a < DP; a++) drive_write(a, 4'hF, $urandom);
      random_ops("rand_rw", 150);
   endtask

   task automatic test_priority_test_mode();
      bus.ram_cs = 1'b1; bus.ram_we = 1'b0; bus.ram_addr = AW'($urandom_range(0, DP - 1));
      bus.ram_ls = 1'b1; bus.ram_sd = 1'b1;
      tick();
      bus.ram_cs = 1'b0;
      model_dout = '0;
      vectors++; if (bus.ram_dout_vld !== 1'b0) begin miscompares++; $display("FAIL prio_vld got %b want 0", bus.ram_dout_vld); end
      vectors++; if (bus.ram_rdy !== 1'b0) begin miscompares++; $display("FAIL prio_rdy got %b want 0", bus.ram_rdy); end
      vectors++; if (bus.ram_dout !== '0) begin miscompares++; $display("FAIL prio_sd_dout got %h want 0", bus.ram_dout); end
      bus.ram_ls = 1'b0; bus.ram_sd = 1'b0;
      for (int k = 0; k < DP + 1; k++) tick();
      vectors++; if (bus.ram_rdy !== 1'b1) begin miscompares++; $display("FAIL prio_run_rdy got %b want 1", bus.ram_rdy); end
      for (int a = 0; a < DP; a++) model_mem[a] = '0;
      bus.test_mode = 1'b1;
      bus.ram_ls = 1'b1; bus.ram_ds = 1'b1; bus.ram_sd = 1'b1;
      random_ops("test_mode", 30);
      idle_inputs();
   endtask

   task automatic test_shutdown();
      for (int a = 0; a < DP; a++) drive_write(a, 4'hF, 32'hFFFFFFFF);
      drive_read(9);
      model_dout = model_mem[9];
      vectors++; if (bus.ram_dout !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL sd_prefill got %h want ffffffff", bus.ram_dout); end
      bus.ram_sd = 1'b1;
      tick();
      model_dout = '0;
      vectors++; if (bus.ram_dout !== '0 || bus.ram_rdy !== 1'b0) begin
         miscompares++; $display("FAIL sd_entry dout/rdy got %h/%b want 0/0", bus.ram_dout, bus.ram_rdy);
      end
      tick(); tick();
      bus.ram_sd = 1'b0;
      for (int k = 0; k < DP; k++) begin
         tick();
         vectors++; if (bus.ram_rdy !== 1'b0) begin miscompares++; $display("FAIL sd_init_rdy[%0d] got %b want 0", k, bus.ram_rdy); end
      end
      tick();
      vectors++; if (bus.ram_rdy !== 1'b1) begin miscompares++; $display("FAIL sd_done_rdy got %b want 1", bus.ram_rdy); end
      for (int a = 0; a < DP; a++) model_mem[a] = '0;
      for (int a = 0; a < DP; a++) begin
         drive_read(a);
         vectors++; if (bus.ram_dout !== '0 || bus.ram_dout_vld !== 1'b1) begin
            miscompares++; $display("FAIL sd_zero[%0d] got %h/%b want 0/1", a, bus.ram_dout, bus.ram_dout_vld);
         end
      end
   endtask

   task automatic test_reset_mid_init();
      for (int a = 0; a < DP; a++) drive_write(a, 4'hF, $urandom | 32'h1);
      bus.ram_sd = 1'b1;
      tick();
      bus.ram_sd = 1'b0;
      tick();                               // now in INIT at index 0
      for (int k = 0; k < 7; k++) tick();   // index 7
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_dout = '0;
      vectors++; if (bus.ram_rdy !== 1'b1) begin miscompares++; $display("FAIL rst_init_rdy got %b want 1", bus.ram_rdy); end
      vectors++; if (bus.ram_dout !== '0) begin miscompares++; $display("FAIL rst_init_dout got %h want 0", bus.ram_dout); end
      vectors++; if (bus.ram_dout_vld !== 1'b0) begin miscompares++; $display("FAIL rst_init_vld got %b want 0", bus.ram_dout_vld); end
      for (int a = 0; a < 7; a++) begin
         drive_read(a);
         vectors++; if (bus.ram_dout !== '0 || bus.ram_dout_vld !== 1'b1) begin
            miscompares++; $display("FAIL rst_init_zero[%0d] got %h/%b want 0/1", a, bus.ram_dout, bus.ram_dout_vld);
         end
      end
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_masked_rw();
      test_light_sleep();
      test_ds_abort();
      test_random_rw();
      test_priority_test_mode();
      test_shutdown();
      test_reset_mid_init();
      tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
`default_nettype wire
